// File: rtl/riscv_wb_pkg.sv
// Shared writeback definitions: default datapath width and the load size/sign encodings.
package riscv_wb_pkg;

  localparam int XLEN_DEF = 64;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/load_extend.sv
// Load data extension: selects the low byte/half/word of the raw doubleword and sign- or zero-extends it.
module load_extend
  import riscv_wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic        [2:0]      funct3,
  input  logic        [XLEN-1:0] raw,
  output logic signed [XLEN-1:0] ext
);

  // The narrow widths assume XLEN >= 64; the unused 111 encoding yields zero.
  always_comb begin
    ext = '0;
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){raw[7]}},   raw[7:0]};
      F3_LH:   ext = {{(XLEN-16){raw[15]}}, raw[15:0]};
      F3_LW:   ext = {{(XLEN-32){raw[31]}}, raw[31:0]};
      F3_LD:   ext = raw;
      F3_LBU:  ext = {{(XLEN-8){1'b0}},     raw[7:0]};
      F3_LHU:  ext = {{(XLEN-16){1'b0}},    raw[15:0]};
      F3_LWU:  ext = {{(XLEN-32){1'b0}},    raw[31:0]};
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Dual-issue writeback stage: one register stage, load extension, x0/WAW write suppression, retire counter.
// Define WB_BYPASS_EN to add the fwd_* forwarding outputs for same-cycle decode forwarding.
module wb_stage
  import riscv_wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    valid_in1,
  input  logic                    valid_in2,
  input  logic        [4:0]       rd_in1,
  input  logic        [4:0]       rd_in2,
  input  logic signed [XLEN-1:0]  alu_res1,
  input  logic signed [XLEN-1:0]  alu_res2,
  input  logic                    mem_read1,
  input  logic                    mem_read2,
  input  logic        [2:0]       funct3_1,
  input  logic        [2:0]       funct3_2,
  input  logic        [XLEN-1:0]  load_data1,
  input  logic        [XLEN-1:0]  load_data2,
  output logic                    Wen1,
  output logic                    Wen2,
  output logic        [4:0]       Rd_addr1,
  output logic        [4:0]       Rd_addr2,
  output logic signed [XLEN-1:0]  write_data1,
  output logic signed [XLEN-1:0]  write_data2,
`ifdef WB_BYPASS_EN
  output logic                    fwd_valid1,
  output logic                    fwd_valid2,
  output logic        [4:0]       fwd_rd1,
  output logic        [4:0]       fwd_rd2,
  output logic signed [XLEN-1:0]  fwd_data1,
  output logic signed [XLEN-1:0]  fwd_data2,
`endif
  output logic        [CNT_W-1:0] retire_count
);

  logic signed [XLEN-1:0] ext1, ext2;
  logic signed [XLEN-1:0] wdata1, wdata2;
  logic                   vld_in1, vld_in2;
  logic                   vld_p0_1, vld_p0_2;

  load_extend #(.XLEN(XLEN)) u_ext1 (.funct3(funct3_1), .raw(load_data1), .ext(ext1));
  load_extend #(.XLEN(XLEN)) u_ext2 (.funct3(funct3_2), .raw(load_data2), .ext(ext2));

  // Flush and stall both turn the incoming slot into a bubble.
  assign vld_in1 = valid_in1 & ~stall & ~flush;
  assign vld_in2 = valid_in2 & ~stall & ~flush;
  assign wdata1  = mem_read1 ? ext1 : alu_res1;
  assign wdata2  = mem_read2 ? ext2 : alu_res2;

  // ---- stage p0: writeback register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_1     <= 1'b0;
      vld_p0_2     <= 1'b0;
      Rd_addr1     <= '0;
      Rd_addr2     <= '0;
      write_data1  <= '0;
      write_data2  <= '0;
      retire_count <= '0;
    end else begin
      vld_p0_1     <= vld_in1;
      vld_p0_2     <= vld_in2;
      Rd_addr1     <= rd_in1;
      Rd_addr2     <= rd_in2;
      write_data1  <= wdata1;
      write_data2  <= wdata2;
      retire_count <= retire_count + CNT_W'(vld_in1) + CNT_W'(vld_in2);
    end
  end

  // Enables decode only registered state; the younger slot wins a same-rd collision.
  assign Wen1 = vld_p0_1 && (Rd_addr1 != 5'd0) && !(vld_p0_2 && (Rd_addr2 == Rd_addr1));
  assign Wen2 = vld_p0_2 && (Rd_addr2 != 5'd0);

`ifdef WB_BYPASS_EN
  assign fwd_valid1 = Wen1;
  assign fwd_valid2 = Wen2;
  assign fwd_rd1    = Rd_addr1;
  assign fwd_rd2    = Rd_addr2;
  assign fwd_data1  = write_data1;
  assign fwd_data2  = write_data2;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scoreboard of expected writeback outputs, plus a CNT_W=4 instance for wrap.
module tb_wb_stage;

  localparam int XLEN  = 64;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0, flush = 1'b0;
  logic valid_in1 = 1'b0, valid_in2 = 1'b0;
  logic [4:0] rd_in1 = '0, rd_in2 = '0;
  logic signed [XLEN-1:0] alu_res1 = '0, alu_res2 = '0;
  logic mem_read1 = 1'b0, mem_read2 = 1'b0;
  logic [2:0] funct3_1 = '0, funct3_2 = '0;
  logic [XLEN-1:0] load_data1 = '0, load_data2 = '0;

  logic Wen1, Wen2;
  logic [4:0] Rd_addr1, Rd_addr2;
  logic signed [XLEN-1:0] write_data1, write_data2;
  logic [CNT_W-1:0] retire_count;

  logic s_Wen1, s_Wen2;
  logic [4:0] s_Rd_addr1, s_Rd_addr2;
  logic signed [XLEN-1:0] s_write_data1, s_write_data2;
  logic [3:0] s_retire_count;

`ifdef WB_BYPASS_EN
  logic fv1, fv2, sfv1, sfv2;
  logic [4:0] frd1, frd2, sfrd1, sfrd2;
  logic signed [XLEN-1:0] fd1, fd2, sfd1, sfd2;
`endif

  wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .valid_in1(valid_in1), .valid_in2(valid_in2), .rd_in1(rd_in1), .rd_in2(rd_in2),
    .alu_res1(alu_res1), .alu_res2(alu_res2), .mem_read1(mem_read1), .mem_read2(mem_read2),
    .funct3_1(funct3_1), .funct3_2(funct3_2), .load_data1(load_data1), .load_data2(load_data2),
    .Wen1(Wen1), .Wen2(Wen2), .Rd_addr1(Rd_addr1), .Rd_addr2(Rd_addr2),
    .write_data1(write_data1), .write_data2(write_data2),
`ifdef WB_BYPASS_EN
    .fwd_valid1(fv1), .fwd_valid2(fv2), .fwd_rd1(frd1), .fwd_rd2(frd2),
    .fwd_data1(fd1), .fwd_data2(fd2),
`endif
    .retire_count(retire_count)
  );

  wb_stage #(.XLEN(XLEN), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .valid_in1(valid_in1), .valid_in2(valid_in2), .rd_in1(rd_in1), .rd_in2(rd_in2),
    .alu_res1(alu_res1), .alu_res2(alu_res2), .mem_read1(mem_read1), .mem_read2(mem_read2),
    .funct3_1(funct3_1), .funct3_2(funct3_2), .load_data1(load_data1), .load_data2(load_data2),
    .Wen1(s_Wen1), .Wen2(s_Wen2), .Rd_addr1(s_Rd_addr1), .Rd_addr2(s_Rd_addr2),
    .write_data1(s_write_data1), .write_data2(s_write_data2),
`ifdef WB_BYPASS_EN
    .fwd_valid1(sfv1), .fwd_valid2(sfv2), .fwd_rd1(sfrd1), .fwd_rd2(sfrd2),
    .fwd_data1(sfd1), .fwd_data2(sfd2),
`endif
    .retire_count(s_retire_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w1;
    logic        w2;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e, g;
  int checks = 0;
  int failures = 0;
  logic [31:0] mcnt = '0;

  function automatic logic [63:0] ext(input logic [2:0] f3, input logic [63:0] raw);
    case (f3)
      3'd0: return {{56{raw[7]}}, raw[7:0]};
      3'd1: return {{48{raw[15]}}, raw[15:0]};
      3'd2: return {{32{raw[31]}}, raw[31:0]};
      3'd3: return raw;
      3'd4: return {56'd0, raw[7:0]};
      3'd5: return {48'd0, raw[15:0]};
      3'd6: return {32'd0, raw[31:0]};
      default: return 64'd0;
    endcase
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o = {Wen1, Wen2, Rd_addr1, Rd_addr2, write_data1, write_data2, retire_count};
    return o;
  endfunction

  // Drive one cycle of inputs, record the expected outputs, then advance to just after the edge.
  task automatic apply(input logic iv1, input logic iv2, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [63:0] x1, input logic [63:0] x2, input logic im1, input logic im2,
                       input logic [2:0] g1, input logic [2:0] g2, input logic [63:0] l1,
                       input logic [63:0] l2, input logic st, input logic fl);
    exp_t x;
    logic a1, a2;
    valid_in1 = iv1; valid_in2 = iv2; rd_in1 = r1; rd_in2 = r2;
    alu_res1 = x1; alu_res2 = x2; mem_read1 = im1; mem_read2 = im2;
    funct3_1 = g1; funct3_2 = g2; load_data1 = l1; load_data2 = l2;
    stall = st; flush = fl;
    a1 = iv1 && !st && !fl;
    a2 = iv2 && !st && !fl;
    mcnt = mcnt + 32'(a1) + 32'(a2);
    x.w1 = a1 && (r1 != 0) && !(a2 && r2 == r1);
    x.w2 = a2 && (r2 != 0);
    x.r1 = r1;
    x.r2 = r2;
    x.d1 = im1 ? ext(g1, l1) : x1;
    x.d2 = im2 ? ext(g2, l2) : x2;
    x.cnt = mcnt;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    #1;
    g = observed();
    checks++;
    if (g !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", g);
    end
    valid_in1 = 1; valid_in2 = 1; rd_in1 = 5'd3; rd_in2 = 5'd4; alu_res1 = 64'd11; alu_res2 = 64'd12;
    #6;
    rst_n = 1'b1;
    #1;
    checks++;
    if (Wen1 !== 1'b0 || Wen2 !== 1'b0 || retire_count !== '0) begin
      failures++;
      $display("FAIL reset_release_no_write got wen=%b%b cnt=%0d exp wen=00 cnt=0", Wen1, Wen2, retire_count);
    end
    valid_in1 = 0; valid_in2 = 0; rd_in1 = 0; rd_in2 = 0; alu_res1 = 0; alu_res2 = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu();
    logic [31:0] c0;
    c0 = retire_count;
    apply(1, 1, 5'd9, 5'd10, 64'd5, -64'sd3, 0, 0, 0, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    g = observed();
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL alu_both got=%h exp=%h", g, e);
    end
    checks++;
    if (write_data2 !== 64'hFFFF_FFFF_FFFF_FFFD || write_data1 !== 64'd5 || retire_count !== c0 + 2) begin
      failures++;
      $display("FAIL alu_values got d1=%h d2=%h cnt=%0d exp d1=5 d2=fffffffffffffffd cnt=%0d",
               write_data1, write_data2, retire_count, c0 + 2);
    end
  endtask

  task automatic test_loads();
    logic [63:0] raw;
    apply(1, 1, 5'd1, 5'd2, 0, 0, 1, 1, 3'd0, 3'd4, 64'h1234_5678_9ABC_DE80,
          64'h1234_5678_9ABC_DE80, 0, 0);
    e = sb.pop_front();
    g = observed();
    checks++;
    if (write_data1 !== 64'hFFFF_FFFF_FFFF_FF80 || write_data2 !== 64'h80 || g !== e) begin
      failures++;
      $display("FAIL lb_lbu got d1=%h d2=%h exp d1=ffffffffffffff80 d2=80", write_data1, write_data2);
    end
    for (int f = 0; f < 8; f++) begin
      raw = {$urandom, $urandom};
      raw[7] = f[0]; raw[15] = f[1]; raw[31] = ~f[0];
      apply(1, 1, 5'(f + 3), 5'(f + 12), 64'hDEAD, 64'hBEEF, 1, 1, 3'(f), 3'(7 - f), raw, ~raw, 0, 0);
      e = sb.pop_front();
      g = observed();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL load_funct3_%0d got=%h exp=%h", f, g, e);
      end
    end
  endtask

  task automatic test_waw_x0();
    apply(1, 1, 5'd7, 5'd7, 64'd100, 64'd200, 0, 0, 0, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    g = observed();
    checks++;
    if (Wen1 !== 1'b0 || Wen2 !== 1'b1 || write_data2 !== 64'd200 || g !== e) begin
      failures++;
      $display("FAIL waw got=%h exp=%h", g, e);
    end
    apply(1, 0, 5'd0, 5'd5, 64'd1, 64'd2, 0, 0, 0, 0, 0, 0, 0, 0);
    e = sb.pop_front();
    g = observed();
    checks++;
    if (Wen1 !== 1'b0 || g !== e) begin
      failures++;
      $display("FAIL x0_write got=%h exp=%h", g, e);
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] c0;
    c0 = retire_count;
    apply(1, 1, 5'd4, 5'd6, 64'd8, 64'd9, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(1, 1, 5'd4, 5'd6, 64'd8, 64'd9, 0, 0, 0, 0, 0, 0, 0, 1);
    apply(1, 1, 5'd4, 5'd6, 64'd8, 64'd9, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      checks++;
      if (e.w1 !== 1'b0 || e.w2 !== 1'b0 || e.cnt !== c0) begin
        failures++;
        $display("FAIL bubble_model_%0d got=%h exp wen=00 cnt=%0d", i, e, c0);
      end
    end
    checks++;
    if (Wen1 !== 1'b0 || Wen2 !== 1'b0 || retire_count !== c0 || Rd_addr2 !== 5'd6) begin
      failures++;
      $display("FAIL stall_flush got wen=%b%b cnt=%0d rd2=%0d exp wen=00 cnt=%0d rd2=6",
               Wen1, Wen2, retire_count, Rd_addr2, c0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      apply(1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
            3'($urandom), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
      e = sb.pop_front();
      g = observed();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL b2b_%0d got=%h exp=%h", i, g, e);
      end
    end
  endtask

  task automatic test_async_reset();
    apply(1, 1, 5'd20, 5'd21, 64'd77, 64'd88, 0, 0, 0, 0, 0, 0, 0, 0);
    void'(sb.pop_front());
    #2;
    rst_n = 1'b0;
    #1;
    g = observed();
    checks++;
    if (g !== '0 || s_retire_count !== 4'd0) begin
      failures++;
      $display("FAIL async_reset got=%h small_cnt=%0d exp=0", g, s_retire_count);
    end
    sb.delete();
    mcnt = '0;
    valid_in1 = 0; valid_in2 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 7; i++) apply(1, 1, 5'd1, 5'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 5'd1, 5'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (s_retire_count !== 4'd15 || retire_count !== 32'd15) begin
      failures++;
      $display("FAIL cnt_preset got small=%0d full=%0d exp 15", s_retire_count, retire_count);
    end
    apply(1, 1, 5'd1, 5'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (s_retire_count !== 4'd1 || retire_count !== 32'd17) begin
      failures++;
      $display("FAIL cnt_wrap got small=%0d full=%0d exp small=1 full=17", s_retire_count, retire_count);
    end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_waw_x0();
    test_stall_flush();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter XLEN, default 64: datapath width.
REQ-002 Parameter CNT_W, default 32: retire counter width.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  upstream pipeline stalled; inserts a bubble into writeback.
REQ-006 flush  input  1  kill instructions entering writeback this cycle.
REQ-007 valid_in1, valid_in2  input  1 each  slot-1 (older) and slot-2 (younger) instruction valid.
REQ-008 rd_in1, rd_in2  input  5 each  destination register address.
REQ-009 alu_res1, alu_res2  input  XLEN each  signed ALU result.
REQ-010 mem_read1, mem_read2  input  1 each  slot is a load; write load data instead of the ALU result.
REQ-011 funct3_1, funct3_2  input  3 each  load size/sign encoding (LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110).
REQ-012 load_data1, load_data2  input  XLEN each  raw doubleword from data memory, with the byte addressed at bits [7:0].
REQ-013 Wen1, Wen2  output  1 each  register file write enables.
REQ-014 Rd_addr1, Rd_addr2  output  5 each  register file write addresses.
REQ-015 write_data1, write_data2  output  XLEN each  signed register file write data.
REQ-016 retire_count  output  CNT_W  number of instructions retired.

Function
REQ-017 Stage SHALL be one registered pipeline stage: inputs captured at rising clk appear on the outputs in the following cycle (latency 1).
REQ-018 Captured valid SHALL be valid_inN & ~stall & ~flush; flush and stall both yield a bubble, and flush takes priority when asserted together.
REQ-019 Rd_addrN and write_dataN SHALL update every cycle regardless of valid; only Wen qualifies the write.
REQ-020 write_dataN SHALL equal alu_resN when mem_readN=0; otherwise the extended load_dataN.
REQ-021 Signed loads (LB/LH/LW) SHALL sign-extend the low 8/16/32 bits to XLEN; LBU/LHU/LWU SHALL zero-extend; LD SHALL pass all 64 bits; funct3=111 SHALL produce 0.
REQ-022 WenN SHALL be 1 only when the registered validN=1 and Rd_addrN != 0 (writes to x0 suppressed).
REQ-023 If both registered slots are valid with equal nonzero rd, then Wen1=0 and Wen2=1, so the younger slot wins (WAW).
REQ-024 retire_count SHALL add popcount of the registered valid1/valid2 each cycle (0, 1 or 2); x0 writes and WAW-suppressed writes still count; wraps modulo 2^CNT_W.
REQ-025 Outputs SHALL be driven from registers only; there is no combinational input-to-output path, except REQ-030.

Reset
REQ-026 rst_n=0 SHALL immediately clear both valids, Wen1, Wen2, Rd_addr1, Rd_addr2, write_data1, write_data2 and retire_count to 0.
REQ-027 Reset mid-operation SHALL discard in-flight instructions; no write occurs in the first cycle after rst_n deasserts.

Configuration
REQ-028 Macro WB_BYPASS_EN compiles in the forwarding outputs fwd_valid1, fwd_valid2 (1 each), fwd_rd1, fwd_rd2 (5 each) and fwd_data1, fwd_data2 (XLEN each).
REQ-029 Without WB_BYPASS_EN these ports SHALL be absent and behaviour otherwise identical.
REQ-030 With WB_BYPASS_EN, fwd_* SHALL combinationally mirror Wen/Rd_addr/write_data for same-cycle decode forwarding, since the register file has no internal bypass.

Structure
REQ-031 Shared package riscv_wb_pkg SHALL hold the XLEN default and the load funct3 localparams.
REQ-032 Sub-module load_extend (funct3, raw data -> extended data) SHALL be instantiated once per slot.

Verification
REQ-033 Both slots valid, rd 9/10, ALU 5/-3, no load -> next cycle Wen1=Wen2=1, write_data 5 and 0xFFFFFFFFFFFFFFFD, retire_count +2.
REQ-034 Slot-1 LB with load_data=0x...80, slot-2 LBU with the same data -> write_data1=0xFFFFFFFFFFFFFF80, write_data2=0x80.
REQ-035 Both valid, rd1=rd2=7 -> Wen1=0, Wen2=1, write_data2 written; rd_in1=0 -> Wen1=0, count still +1 for that slot.
REQ-036 stall=1 then flush=1 with valid inputs -> Wen1=Wen2=0 for those cycles, retire_count unchanged.
REQ-037 retire_count preset near max (CNT_W=4, value 15) plus two retires -> value 1; rst_n pulsed mid-stream -> all outputs 0 asynchronously.
